// File: rtl/bcd_operand_loader.sv
// Operand-entry stage for the two-digit BCD adder: debounces a push-button and
// collects operand X, then operand Y plus carry-in, into a held, validated set.
module bcd_operand_loader #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_W           = 19
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       load_n,
  input  logic [3:0] digit_in,
  input  logic       cin_in,
  input  logic       consume,
  output logic [3:0] x_out,
  output logic [3:0] y_out,
  output logic       cin_out,
  output logic       valid,
  output logic       digit_err,
  output logic [1:0] phase
);

  typedef enum logic [1:0] {
    StGetX  = 2'b00,
    StGetY  = 2'b01,
    StReady = 2'b10
  } state_e;

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [3:0]       BcdMax = 4'd9;

  logic [1:0]       sync_q, sync_d;
  logic             deb_q, deb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_q, press_d;

  state_e           state_q, state_d;
  logic [3:0]       x_q, x_d;
  logic [3:0]       y_q, y_d;
  logic             cin_q, cin_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;

  logic             accept;
  logic             reject;

  // sync_q[1] is the synchronised key level; the debounced level only follows it
  // after DEBOUNCE_CYCLES consecutive differing samples.
  always_comb begin
    sync_d  = {sync_q[0], load_n};
    deb_d   = deb_q;
    cnt_d   = '0;
    press_d = 1'b0;
    if (sync_q[1] != deb_q) begin
      if (cnt_q == CntMax) begin
        deb_d   = sync_q[1];
        press_d = ~sync_q[1];
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  assign accept = press_q & (digit_in <= BcdMax);
  assign reject = press_q & (digit_in >  BcdMax);

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    cin_d   = cin_q;
    valid_d = valid_q;
    err_d   = err_q;
    if (reject) begin
      err_d = 1'b1;
    end
    unique case (state_q)
      StGetX: begin
        if (accept) begin
          x_d     = digit_in;
          err_d   = 1'b0;
          state_d = StGetY;
        end
      end
      StGetY: begin
        if (accept) begin
          y_d     = digit_in;
          cin_d   = cin_in;
          err_d   = 1'b0;
          valid_d = 1'b1;
          state_d = StReady;
        end
      end
      StReady: begin
        // A new accepted digit starts the next entry and outranks consume.
        if (accept) begin
          x_d     = digit_in;
          err_d   = 1'b0;
          valid_d = 1'b0;
          state_d = StGetY;
        end else if (consume) begin
          valid_d = 1'b0;
          state_d = StGetX;
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = StGetX;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      sync_q  <= 2'b11;
      deb_q   <= 1'b1;
      cnt_q   <= '0;
      press_q <= 1'b0;
      state_q <= StGetX;
      x_q     <= 4'd0;
      y_q     <= 4'd0;
      cin_q   <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      cin_q   <= cin_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign x_out     = x_q;
  assign y_out     = y_q;
  assign cin_out   = cin_q;
  assign valid     = valid_q;
  assign digit_err = err_q;
  assign phase     = state_q;

endmodule

// File: tb/tb_bcd_operand_loader.sv
// Bench for bcd_operand_loader: directed scenarios plus random key/consume/reset
// traffic, every cycle compared against a behavioural model of the entry rules.
module tb_bcd_operand_loader;

  localparam int unsigned Deb = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       load_n;
  logic [3:0] digit_in;
  logic       cin_in;
  logic       consume;
  logic [3:0] x_out;
  logic [3:0] y_out;
  logic       cin_out;
  logic       valid;
  logic       digit_err;
  logic [1:0] phase;

  bcd_operand_loader #(
    .DEBOUNCE_CYCLES(Deb),
    .CNT_W          (3)
  ) u_dut (
    .CLOCK_50 (clk),
    .reset    (reset),
    .load_n   (load_n),
    .digit_in (digit_in),
    .cin_in   (cin_in),
    .consume  (consume),
    .x_out    (x_out),
    .y_out    (y_out),
    .cin_out  (cin_out),
    .valid    (valid),
    .digit_err(digit_err),
    .phase    (phase)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic        chk_en   = 1'b0;

  task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: raw key samples kept as a history; the debounced level flips
  // once the last Deb synchronised samples all disagree with it.
  logic       m_hist [0:Deb];
  logic       m_deb;
  logic       m_pend;
  logic [1:0] m_state;
  logic [3:0] m_x, m_y;
  logic       m_cin, m_valid, m_err;

  task automatic model_step();
    logic acc, rej, all_diff;
    if (reset) begin
      m_state = 2'd0; m_x = 4'd0; m_y = 4'd0; m_cin = 1'b0;
      m_valid = 1'b0; m_err = 1'b0; m_deb = 1'b1; m_pend = 1'b0;
      for (int i = 0; i <= Deb; i++) m_hist[i] = 1'b1;
      return;
    end
    acc = m_pend && (digit_in <= 4'd9);
    rej = m_pend && (digit_in > 4'd9);
    if (rej) m_err = 1'b1;
    case (m_state)
      2'd0: if (acc) begin m_x = digit_in; m_err = 1'b0; m_state = 2'd1; end
      2'd1: if (acc) begin
        m_y = digit_in; m_cin = cin_in; m_err = 1'b0; m_valid = 1'b1; m_state = 2'd2;
      end
      default: begin
        if (acc) begin
          m_x = digit_in; m_valid = 1'b0; m_err = 1'b0; m_state = 2'd1;
        end else if (consume) begin
          m_valid = 1'b0; m_state = 2'd0;
        end
      end
    endcase
    // m_hist[k] holds the raw sample from k+1 edges ago; sync lags by two edges.
    all_diff = 1'b1;
    for (int i = 1; i <= Deb; i++) if (m_hist[i] == m_deb) all_diff = 1'b0;
    m_pend = 1'b0;
    if (all_diff) begin
      m_pend = m_deb;
      m_deb  = ~m_deb;
    end
    for (int i = Deb; i > 0; i--) m_hist[i] = m_hist[i-1];
    m_hist[0] = load_n;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      check_eq("model_xy", {8'd0, x_out, y_out}, {8'd0, m_x, m_y});
      check_eq("model_flags", {11'd0, cin_out, valid, digit_err, phase},
               {11'd0, m_cin, m_valid, m_err, m_state});
    end
  end

  task automatic press(input logic [3:0] d, input logic c);
    digit_in = d;
    cin_in   = c;
    load_n   = 1'b0;
    repeat (8) @(negedge clk);
    load_n = 1'b1;
    repeat (Deb + 4) @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int unsigned run;
    reset = 1'b1; load_n = 1'b1; digit_in = 4'd0; cin_in = 1'b0; consume = 1'b0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    reset  = 1'b0;
    check_eq("rst_outputs", {x_out, y_out, 1'b0, cin_out, valid, digit_err, phase}, 16'd0);

    // Strobe timing: first low sample at edge N, FSM acts at edge N+6.
    digit_in = 4'd7;
    load_n   = 1'b0;
    repeat (6) @(negedge clk);
    check_eq("t1_before_strobe", {14'd0, phase}, 16'd0);
    @(negedge clk);
    check_eq("t1_phase", {14'd0, phase}, 16'd1);
    check_eq("t1_x", {12'd0, x_out}, 16'd7);
    repeat (13) @(negedge clk);
    load_n = 1'b1;
    repeat (Deb + 4) @(negedge clk);
    check_eq("t1_single_strobe", {14'd0, phase}, 16'd1);

    // Bounce shorter than the debounce window.
    do_reset();
    digit_in = 4'd5;
    load_n = 1'b0; repeat (2) @(negedge clk);
    load_n = 1'b1; @(negedge clk);
    load_n = 1'b0; repeat (2) @(negedge clk);
    load_n = 1'b1; repeat (10) @(negedge clk);
    check_eq("t2_phase", {14'd0, phase}, 16'd0);
    check_eq("t2_x", {12'd0, x_out}, 16'd0);

    // Full entry and consume.
    press(4'd3, 1'b0);
    press(4'd9, 1'b1);
    check_eq("t3_data", {7'd0, x_out, y_out, cin_out}, {7'd0, 4'd3, 4'd9, 1'b1});
    check_eq("t3_ready", {13'd0, valid, phase}, {13'd0, 1'b1, 2'd2});
    consume = 1'b1; @(negedge clk); consume = 1'b0;
    check_eq("t3_consumed", {13'd0, valid, phase}, 16'd0);
    check_eq("t3_retained", {7'd0, x_out, y_out, cin_out}, {7'd0, 4'd3, 4'd9, 1'b1});

    // Invalid digit in GET_Y, then a valid one.
    press(4'd3, 1'b0);
    press(4'd12, 1'b0);
    check_eq("t4_err", {13'd0, digit_err, phase}, {13'd0, 1'b1, 2'd1});
    check_eq("t4_y_kept", {12'd0, y_out}, 16'd9);
    press(4'd5, 1'b0);
    check_eq("t4_recover", {11'd0, digit_err, valid, y_out}, {11'd0, 1'b0, 1'b1, 4'd5});

    // Consume and accepted press in the same strobe cycle.
    digit_in = 4'd4;
    load_n   = 1'b0;
    repeat (6) @(negedge clk);
    consume = 1'b1; @(negedge clk); consume = 1'b0;
    check_eq("t5_x", {12'd0, x_out}, 16'd4);
    check_eq("t5_state", {13'd0, valid, phase}, {13'd0, 1'b0, 2'd1});
    repeat (2) @(negedge clk);
    load_n = 1'b1;
    repeat (Deb + 4) @(negedge clk);

    // Reset while in GET_Y with the key held down, key released during reset.
    load_n = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    load_n = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check_eq("t6_cleared", {x_out, y_out, 1'b0, cin_out, valid, digit_err, phase}, 16'd0);
    repeat (12) @(negedge clk);
    check_eq("t6_no_strobe", {14'd0, phase}, 16'd0);
    press(4'd6, 1'b0);
    check_eq("t6_repress", {10'd0, phase, x_out}, {10'd0, 2'd1, 4'd6});

    // Random key timing, digits, consume pulses and occasional resets.
    run = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (run == 0) begin
        load_n = ~load_n;
        run    = $urandom_range(1, 12);
      end
      run--;
      if ($urandom_range(0, 3) == 0) digit_in = 4'($urandom_range(0, 15));
      cin_in  = 1'($urandom_range(0, 1));
      consume = ($urandom_range(0, 7) == 0);
      reset   = ($urandom_range(0, 399) == 0);
      @(negedge clk);
    end
    load_n = 1'b1; consume = 1'b0; reset = 1'b0;
    repeat (12) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
